uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte-stream requesters. The transmitter has no busy output, so this block also paces it. It grants one requester at a time and accepts one byte over a valid/ready handshake. It then issues a single-cycle load strobe with the byte and blocks further loads until a full frame time has elapsed. A requester can hold the grant across a multi-byte packet until its `last` flag; a lock timeout prevents a stalled requester from blocking the others.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_sched.sv | 142 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler.
// Frame timing is derived from clock rate, baud rate and frame length.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } sched_state_t;

    localparam int UART_FRAME_BITS = 10;

    function automatic int frame_cycles(
        input int clk_per,
        input int baud,
        input int bits,
        input int gap
    );
        return (clk_per / baud) * bits + gap;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first requester after i_last, wrapping.
// Purely combinational; o_any flags that some request is present.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_last,
    output logic [GW-1:0]      o_win,
    output logic               o_any
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(i_last) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && i_req[GW'(w_idx)]) begin
                w_found = 1'b1;
                o_win   = GW'(w_idx);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among requesters.
// Paces byte loads to one per frame and supports locked multi-byte packets.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLK_PER      = 50_000_000,
    parameter int BAND_RATE    = 9600,
    parameter int NUM_REQ      = 4,
    parameter int FRAME_BITS   = UART_FRAME_BITS,
    parameter int GAP_CYCLES   = 0,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [8*NUM_REQ-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_data_valid_o,
    output logic [7:0]                 tx_data_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int FRAME_CYC = frame_cycles(CLK_PER, BAND_RATE,
                                            FRAME_BITS, GAP_CYCLES);
    localparam int FW = $clog2(FRAME_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int GW = $clog2(NUM_REQ);

    localparam logic [FW-1:0] FRAME_END = FW'(FRAME_CYC - 1);
    localparam logic [TW-1:0] LOCK_END  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);

    sched_state_t r_state;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_tcnt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic          r_lock;
    logic          r_txv;
    logic [7:0]    r_txd;
    logic          r_to;

    logic [GW-1:0]      w_win;
    logic               w_any;
    logic               w_valid_g;
    logic               w_last_g;
    logic [7:0]         w_data_g;
    logic [NUM_REQ-1:0] w_ready;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .i_req  (req_valid_i),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    assign w_valid_g = req_valid_i[r_grant];
    assign w_last_g  = req_last_i[r_grant];
    assign w_data_g  = req_data_i[{r_grant, 3'b000} +: 8];

    // Only the current grantee ever sees ready, and only while in ISSUE.
    always_comb begin
        w_ready = '0;
        if (r_state == S_ISSUE) w_ready[r_grant] = w_valid_g;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_fcnt  <= '0;
            r_tcnt  <= '0;
            r_grant <= '0;
            r_last  <= GRANT_RST;
            r_lock  <= 1'b0;
            r_txv   <= 1'b0;
            r_txd   <= '0;
            r_to    <= 1'b0;
        end else begin
            r_txv <= 1'b0;
            r_to  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_valid_g) begin
                        r_txd   <= w_data_g;
                        r_txv   <= 1'b1;
                        r_lock  <= !w_last_g;
                        r_fcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_fcnt == FRAME_END) begin
                        if (!r_lock) begin
                            r_last  <= r_grant;
                            r_state <= S_IDLE;
                        end else if (w_valid_g) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_tcnt  <= '0;
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_valid_g) begin
                        r_state <= S_ISSUE;
                    end else if (r_tcnt == LOCK_END) begin
                        r_to    <= 1'b1;
                        r_lock  <= 1'b0;
                        r_last  <= r_grant;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o     = w_ready;
    assign tx_data_valid_o = r_txv;
    assign tx_data_o       = r_txd;
    assign grant_id_o      = r_grant;
    assign busy_o          = (r_state != S_IDLE);
    assign timeout_o       = r_to;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched with a transaction-level schedule model.
// FRAME_CYC = 100, LOCK_TIMEOUT = 50, four requesters.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int FC = 100;
    localparam int LT = 50;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req_valid_i = '0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           tx_data_valid_o;
    logic [7:0]     tx_data_o;
    logic [1:0]     grant_id_o;
    logic           busy_o;
    logic           timeout_o;

    typedef struct {
        int         cyc;
        int         gid;
        logic [7:0] data;
    } ev_t;

    ev_t        sq[$];
    ev_t        eq[$];
    int         tq[$];
    logic [8:0] srcq[N][$];
    logic [8:0] mq[N][$];

    int g_cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int s_cyc;
    logic [N-1:0] s_ready;
    logic         s_busy, s_to, s_txv;
    logic [1:0]   s_gid;
    logic [7:0]   s_txd;

    uart_tx_sched #(
        .CLK_PER      (1000),
        .BAND_RATE    (100),
        .NUM_REQ      (N),
        .FRAME_BITS   (10),
        .GAP_CYCLES   (0),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .tx_data_valid_o (tx_data_valid_o),
        .tx_data_o       (tx_data_o),
        .grant_id_o      (grant_id_o),
        .busy_o          (busy_o),
        .timeout_o       (timeout_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) g_cyc <= g_cyc + 1;

    // Requesters present the head of their queue; valid stays up until taken.
    task automatic refresh();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0) begin
                v[k]       = 1'b1;
                l[k]       = srcq[k][0][8];
                d[8*k +: 8] = srcq[k][0][7:0];
            end
        end
        req_valid_i = v;
        req_last_i  = l;
        req_data_i  = d;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        srcq[k].push_back({l, d});
        mq[k].push_back({l, d});
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            srcq[k].delete();
            mq[k].delete();
        end
        sq.delete();
        eq.delete();
        tq.delete();
    endtask

    task automatic step();
        logic [N-1:0] hs;
        ev_t          e;
        @(negedge clk);
        s_cyc   = g_cyc;
        s_ready = req_ready_o;
        s_busy  = busy_o;
        s_to    = timeout_o;
        s_txv   = tx_data_valid_o;
        s_txd   = tx_data_o;
        s_gid   = grant_id_o;
        if (tx_data_valid_o) begin
            e.cyc = g_cyc; e.gid = int'(grant_id_o); e.data = tx_data_o;
            sq.push_back(e);
        end
        if (timeout_o) tq.push_back(g_cyc);
        n_cmp++;
        if (!$onehot0(req_ready_o)) begin
            n_bad++;
            $display("FAIL ready_onehot cyc=%0d got=%b want=one-hot-or-zero",
                     g_cyc, req_ready_o);
        end
        n_cmp++;
        if ((req_ready_o & ~req_valid_i) != '0 || (req_ready_o != '0 && !busy_o)) begin
            n_bad++;
            $display("FAIL ready_scope cyc=%0d got ready=%b valid=%b busy=%b want=ready only to valid grantee while busy",
                     g_cyc, req_ready_o, req_valid_i, busy_o);
        end
        hs = req_ready_o & req_valid_i;
        @(posedge clk);
        #1;
        if (!rst_i) begin
            for (int k = 0; k < N; k++)
                if (hs[k]) void'(srcq[k].pop_front());
        end
        refresh();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_all();
        refresh();
        run(2);
        rst_i = 1'b0;
        sq.delete();
        tq.delete();
    endtask

    // Schedule model: round-robin over requesters with queued packets, a packet
    // is sent whole; 101 cycles between bytes of a packet, 102 between packets.
    task automatic build_model(input int c0);
        int         last, t, w, idx;
        logic [8:0] b;
        ev_t        e;
        last = N - 1;
        t    = c0 + 2;
        forever begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                idx = (last + i) % N;
                if (w < 0 && mq[idx].size() > 0) w = idx;
            end
            if (w < 0) break;
            do begin
                b = mq[w].pop_front();
                e.cyc = t; e.gid = w; e.data = b[7:0];
                eq.push_back(e);
                t += b[8] ? FC + 2 : FC + 1;
            end while (!b[8] && mq[w].size() > 0);
            last = w;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_all();
        push(0, 8'h3C, 1'b1);
        refresh();
        run(3);
        n_cmp++; if (s_ready !== '0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", s_ready); end
        n_cmp++; if (s_txv !== 1'b0) begin n_bad++; $display("FAIL reset_txv got=%b want=0", s_txv); end
        n_cmp++; if (s_txd !== 8'h00) begin n_bad++; $display("FAIL reset_txd got=%h want=00", s_txd); end
        n_cmp++; if (s_gid !== 2'd0) begin n_bad++; $display("FAIL reset_gid got=%0d want=0", s_gid); end
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", s_busy); end
        n_cmp++; if (s_to !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b want=0", s_to); end
        rst_i = 1'b0;
        clear_all();
        refresh();
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        push(0, 8'hA5, 1'b1);
        refresh();
        c0 = g_cyc;
        for (int i = 0; i < 110; i++) begin
            step();
            if (s_cyc == c0 + 1) begin
                n_cmp++;
                if (s_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b want=0001", s_ready); end
            end
            if (s_cyc == c0 + 2) begin
                n_cmp++;
                if (s_txv !== 1'b1 || s_txd !== 8'hA5) begin
                    n_bad++; $display("FAIL single_strobe got=%b/%h want=1/a5", s_txv, s_txd);
                end
            end
            if (s_cyc == c0 + 101) begin
                n_cmp++;
                if (s_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_hi got=%b want=1", s_busy); end
            end
            if (s_cyc == c0 + 102) begin
                n_cmp++;
                if (s_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_lo got=%b want=0", s_busy); end
            end
        end
        n_cmp++;
        if (sq.size() != 1) begin
            n_bad++; $display("FAIL single_count got=%0d want=1", sq.size());
        end else begin
            n_cmp++;
            if (sq[0].cyc != c0 + 2) begin n_bad++; $display("FAIL single_cyc got=%0d want=%0d", sq[0].cyc, c0 + 2); end
        end
    endtask

    task automatic test_fairness();
        int         c0;
        int         eg[5];
        logic [7:0] ed[5];
        eg = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ed[i] = 8'($urandom);
            push(eg[i], ed[i], 1'b1);
        end
        refresh();
        c0 = g_cyc;
        run(5 * (FC + 2) + 10);
        n_cmp++;
        if (sq.size() != 5) begin
            n_bad++; $display("FAIL fair_count got=%0d want=5", sq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (sq[i].gid != eg[i] || sq[i].data !== ed[i] || sq[i].cyc != c0 + 2 + (FC + 2) * i) begin
                    n_bad++;
                    $display("FAIL fair_%0d got=g%0d/%h@%0d want=g%0d/%h@%0d", i, sq[i].gid,
                             sq[i].data, sq[i].cyc, eg[i], ed[i], c0 + 2 + (FC + 2) * i);
                end
            end
        end
    endtask

    task automatic test_burst();
        int         c0;
        logic [7:0] d2;
        int         wc[3], wg[3];
        logic [7:0] wd[3];
        do_reset();
        d2 = 8'($urandom);
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b1);
        push(2, d2, 1'b1);
        refresh();
        c0 = g_cyc;
        wc = '{c0 + 2, c0 + 103, c0 + 205};
        wg = '{1, 1, 2};
        wd = '{8'h11, 8'h22, d2};
        run(220);
        n_cmp++;
        if (sq.size() != 3) begin
            n_bad++; $display("FAIL burst_count got=%0d want=3", sq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (sq[i].gid != wg[i] || sq[i].data !== wd[i] || sq[i].cyc != wc[i]) begin
                    n_bad++;
                    $display("FAIL burst_%0d got=g%0d/%h@%0d want=g%0d/%h@%0d", i,
                             sq[i].gid, sq[i].data, sq[i].cyc, wg[i], wd[i], wc[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int         c0, r0;
        logic [7:0] d3, d0;
        do_reset();
        d3 = 8'($urandom);
        d0 = 8'($urandom);
        push(3, d3, 1'b0);
        refresh();
        c0 = g_cyc;
        run(3);
        push(0, d0, 1'b1);
        refresh();
        r0 = -1;
        for (int i = 0; i < 170; i++) begin
            step();
            if (r0 < 0 && s_ready[0]) r0 = s_cyc;
            if (s_cyc == c0 + 140) begin
                n_cmp++;
                if (s_gid !== 2'd3 || s_busy !== 1'b1) begin
                    n_bad++; $display("FAIL hold_grant got=g%0d/busy%b want=g3/busy1", s_gid, s_busy);
                end
            end
        end
        n_cmp++;
        if (tq.size() != 1 || tq[0] != c0 + 2 + FC + LT) begin
            n_bad++; $display("FAIL timeout_pulse got=%0d pulses first@%0d want=1@%0d", tq.size(),
                              (tq.size() > 0) ? tq[0] : -1, c0 + 2 + FC + LT);
        end
        n_cmp++;
        if (r0 != c0 + 3 + FC + LT) begin
            n_bad++; $display("FAIL timeout_regrant got=%0d want=%0d", r0, c0 + 3 + FC + LT);
        end
        n_cmp++;
        if (sq.size() != 2) begin
            n_bad++; $display("FAIL timeout_count got=%0d want=2", sq.size());
        end else begin
            n_cmp++;
            if (sq[0].gid != 3 || sq[0].data !== d3 || sq[1].gid != 0 || sq[1].data !== d0 ||
                sq[1].cyc != c0 + 4 + FC + LT) begin
                n_bad++;
                $display("FAIL timeout_seq got=g%0d/%h g%0d/%h@%0d want=g3/%h g0/%h@%0d",
                         sq[0].gid, sq[0].data, sq[1].gid, sq[1].data, sq[1].cyc, d3, d0, c0 + 4 + FC + LT);
            end
        end
    endtask

    task automatic test_reset_mid();
        int         c0, c1;
        logic [7:0] d, d2;
        do_reset();
        d  = 8'($urandom_range(1, 255));
        d2 = 8'($urandom);
        push(0, d, 1'b1);
        refresh();
        c0 = g_cyc;
        run(42);
        rst_i = 1'b1;
        step();
        n_cmp++;
        if (s_busy !== 1'b1 || s_txd !== d) begin
            n_bad++; $display("FAIL mid_pre got=busy%b/%h want=busy1/%h", s_busy, s_txd, d);
        end
        step();
        n_cmp++;
        if (s_busy !== 1'b0 || s_txd !== 8'h00 || s_txv !== 1'b0 || s_gid !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_reset got=busy%b/%h/v%b/g%0d want=busy0/00/v0/g0", s_busy, s_txd, s_txv, s_gid);
        end
        rst_i = 1'b0;
        run(5);
        n_cmp++;
        if (sq.size() != 1) begin n_bad++; $display("FAIL mid_nostrobe got=%0d want=1", sq.size()); end
        push(0, d2, 1'b1);
        refresh();
        c1 = g_cyc;
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_cyc == c1 + 1) begin
                n_cmp++;
                if (s_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ready got=%b want=0001", s_ready); end
            end
        end
        n_cmp++;
        if (sq.size() != 2 || sq[sq.size()-1].cyc != c1 + 2 || sq[sq.size()-1].data !== d2) begin
            n_bad++;
            $display("FAIL mid_serve got=%0d strobes last@%0d/%h want=2 last@%0d/%h", sq.size(),
                     sq[sq.size()-1].cyc, sq[sq.size()-1].data, c1 + 2, d2);
        end
    endtask

    task automatic test_random(input int iter);
        int c0, np, len, tot, bound, m;
        do_reset();
        tot = 0;
        for (int k = 0; k < N; k++) begin
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) begin
                    push(k, 8'($urandom), (b == len - 1));
                    tot++;
                end
            end
        end
        if (tot == 0) push(2, 8'($urandom), 1'b1);
        refresh();
        c0 = g_cyc;
        build_model(c0);
        bound = eq[eq.size()-1].cyc - c0 + 20;
        run(bound);
        n_cmp++;
        if (sq.size() != eq.size()) begin
            n_bad++; $display("FAIL rand%0d_count got=%0d want=%0d", iter, sq.size(), eq.size());
        end
        m = (sq.size() < eq.size()) ? sq.size() : eq.size();
        for (int i = 0; i < m; i++) begin
            n_cmp++;
            if (sq[i].cyc != eq[i].cyc || sq[i].gid != eq[i].gid || sq[i].data !== eq[i].data) begin
                n_bad++;
                $display("FAIL rand%0d_ev%0d got=g%0d/%h@%0d want=g%0d/%h@%0d", iter, i,
                         sq[i].gid, sq[i].data, sq[i].cyc, eq[i].gid, eq[i].data, eq[i].cyc);
            end
        end
        for (int k = 0; k < N; k++) begin
            n_cmp++;
            if (srcq[k].size() != 0) begin
                n_bad++; $display("FAIL rand%0d_drain req%0d got=%0d left want=0", iter, k, srcq[k].size());
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_timeout();
        test_reset_mid();
        for (int it = 0; it < 3; it++) test_random(it);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
